data_memory_bank: RTL and testbench

Parametrised successor to the 8-bit data RAM. It is a single-port synchronous data memory mapped at a configurable address window, with a valid/ready request port and a one-cycle-latency response port. It adds out-of-range error responses, a hardware clear engine and a saturating error counter. It sits between the datapath load/store stage and the data RAM storage.

---
 rtl/data_memory_bank.sv | 144 ++++++++++++++
 tb/tb_data_memory_bank.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/data_memory_bank.sv
// Single-port synchronous data memory mapped at a fixed address window, with
// valid/ready requests, one-cycle responses, a hardware clear engine and error counting.
module data_memory_bank #(
    parameter int    DATA_W         = 8,
    parameter int    ADDR_W         = 8,
    parameter int    BASE_ADDR      = 64,
    parameter int    DEPTH          = 64,
    parameter bit    CLEAR_ON_RESET = 1'b1,
    parameter string INIT_FILE      = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    input  logic              clear,
    output logic              busy,
    output logic [7:0]        err_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Window bounds carry one extra bit so a window ending at 2**ADDR_W still fits.
    localparam logic [ADDR_W:0]  WIN_LO   = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0]  WIN_HI   = (ADDR_W+1)'(BASE_ADDR + DEPTH);
    localparam logic [IDX_W-1:0] BASE_IDX = IDX_W'(BASE_ADDR);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    if (BASE_ADDR + DEPTH > 2**ADDR_W) begin : g_window_check
        $error("data_memory_bank: BASE_ADDR+DEPTH exceeds the ADDR_W address space");
    end

    if (CLEAR_ON_RESET && (INIT_FILE != "")) begin : g_init_check
        $error("data_memory_bank: INIT_FILE cannot be combined with CLEAR_ON_RESET=1");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam state_t RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t           state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic             clr_we;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST_STATE;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        busy      = 1'b0;
        req_ready = 1'b0;
        clr_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (clear) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (clr_idx_q == LAST_IDX) begin
                    state_d   = S_IDLE;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Stage p0: request acceptance and address decode
    logic             acc_p0;
    logic             in_rng_p0;
    logic [IDX_W-1:0] idx_p0;

    assign acc_p0    = req_valid && req_ready;
    assign in_rng_p0 = ({1'b0, req_addr} >= WIN_LO) && ({1'b0, req_addr} < WIN_HI);
    // Low-bit subtraction is exact because an in-range offset is below 2**IDX_W.
    assign idx_p0    = IDX_W'(req_addr) - BASE_IDX;

    // The clear engine and accepted requests never share a cycle, since requests need IDLE.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx_q] <= '0;
        end else if (acc_p0 && req_we && in_rng_p0) begin
            mem[idx_p0] <= req_wdata;
        end
    end

    // Stage p1: registered response and error counter
    logic              vld_p1;
    logic              err_p1;
    logic [DATA_W-1:0] rdata_p1;
    logic [7:0]        err_cnt_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            err_p1     <= 1'b0;
            rdata_p1   <= '0;
            err_cnt_p1 <= '0;
        end else begin
            vld_p1 <= acc_p0;
            err_p1 <= acc_p0 && !in_rng_p0;
            if (acc_p0) begin
                if (!in_rng_p0) begin
                    rdata_p1   <= '0;
                    err_cnt_p1 <= sat_inc(err_cnt_p1);
                end else if (!req_we) begin
                    rdata_p1 <= mem[idx_p0];
                end
            end
        end
    end

    assign rsp_valid = vld_p1;
    assign rsp_err   = err_p1;
    assign rsp_rdata = rdata_p1;
    assign err_count = err_cnt_p1;

endmodule

// File: tb/tb_data_memory_bank.sv
// Directed bench for data_memory_bank: reset clear, read/write, window edges,
// error saturation, clear engine and reset during clear.
module tb_data_memory_bank;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_we = 1'b0;
    logic [7:0] req_addr = 8'd0;
    logic [7:0] req_wdata = 8'd0;
    logic       clear = 1'b0;
    logic       req_ready, rsp_valid, rsp_err, busy;
    logic [7:0] rsp_rdata, err_count;

    int compared = 0;
    int mismatched = 0;
    int cnt;
    int nrsp;

    data_memory_bank #(
        .DATA_W(8), .ADDR_W(8), .BASE_ADDR(64), .DEPTH(64),
        .CLEAR_ON_RESET(1'b1), .INIT_FILE("")
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .clear(clear), .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [7:0] a, input logic [7:0] d);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic rsp(input string tag, input logic err, input logic [7:0] rdata);
        chk({tag, "_valid"}, rsp_valid, 1'b1);
        chk({tag, "_err"}, rsp_err, err);
        chk({tag, "_rdata"}, rsp_rdata, rdata);
    endtask

    initial begin
        // Reset state
        #2;
        cyc(); cyc(); cyc();
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 8'h00);
        chk("rst_err_count", err_count, 8'h00);
        chk("rst_busy", busy, 1'b1);
        chk("rst_ready", req_ready, 1'b0);

        // Clear after reset release lasts exactly DEPTH cycles
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            cyc();
            cnt++;
            if (!busy) break;
        end
        chk("rst_clear_len", cnt, 64);
        chk("idle_ready", req_ready, 1'b1);

        drive(1'b0, 8'd64, 8'h00);
        rsp("rd64_after_clear", 1'b0, 8'h00);
        cyc();
        chk("no_req_valid", rsp_valid, 1'b0);

        // Write then read back-to-back; write response holds rdata
        drive(1'b1, 8'd65, 8'h5A);
        rsp("wr65", 1'b0, 8'h00);
        drive(1'b0, 8'd65, 8'h00);
        rsp("rd65", 1'b0, 8'h5A);
        drive(1'b1, 8'd70, 8'hA5);
        rsp("wr70_hold", 1'b0, 8'h5A);
        drive(1'b0, 8'd70, 8'h00);
        rsp("rd70", 1'b0, 8'hA5);
        drive(1'b1, 8'd127, 8'h77);
        rsp("wr127", 1'b0, 8'hA5);

        // Window boundaries
        drive(1'b0, 8'd63, 8'h00);
        rsp("rd63", 1'b1, 8'h00);
        drive(1'b0, 8'd64, 8'h00);
        rsp("rd64", 1'b0, 8'h00);
        drive(1'b0, 8'd127, 8'h00);
        rsp("rd127", 1'b0, 8'h77);
        drive(1'b0, 8'd128, 8'h00);
        rsp("rd128", 1'b1, 8'h00);
        chk("err_count_2", err_count, 8'd2);
        drive(1'b1, 8'd128, 8'hFF);
        rsp("wr128", 1'b1, 8'h00);
        chk("err_count_3", err_count, 8'd3);
        drive(1'b0, 8'd64, 8'h00);
        rsp("rd64_kept", 1'b0, 8'h00);
        drive(1'b0, 8'd65, 8'h00);
        rsp("rd65_kept", 1'b0, 8'h5A);
        drive(1'b0, 8'd70, 8'h00);
        rsp("rd70_kept", 1'b0, 8'hA5);
        drive(1'b0, 8'd127, 8'h00);
        rsp("rd127_kept", 1'b0, 8'h77);
        cyc();
        chk("idle_valid", rsp_valid, 1'b0);
        chk("idle_rdata_hold", rsp_rdata, 8'h77);

        // Error counter saturation
        for (int i = 0; i < 300; i++) drive(1'b0, 8'd200, 8'h00);
        chk("sat_err_count", err_count, 8'd255);
        chk("sat_rsp_err", rsp_err, 1'b1);
        drive(1'b0, 8'd0, 8'h00);
        chk("sat_hold", err_count, 8'd255);

        // Same-cycle clear and write
        chk("pre_clear_busy", busy, 1'b0);
        clear = 1'b1;
        drive(1'b1, 8'd100, 8'h3C);
        clear = 1'b0;
        chk("clrwr_valid", rsp_valid, 1'b1);
        chk("clrwr_err", rsp_err, 1'b0);
        chk("clrwr_busy", busy, 1'b1);
        chk("clrwr_ready", req_ready, 1'b0);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'd100;
        cnt = 1;
        nrsp = 0;
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (rsp_valid) nrsp++;
            if (!busy) break;
            cnt++;
        end
        req_valid = 1'b0;
        chk("clear_len", cnt, 64);
        chk("clear_blocks_req", nrsp, 0);
        drive(1'b0, 8'd100, 8'h00);
        rsp("rd100_cleared", 1'b0, 8'h00);
        drive(1'b0, 8'd65, 8'h00);
        rsp("rd65_cleared", 1'b0, 8'h00);

        // Reset in the middle of a clear
        drive(1'b1, 8'd120, 8'h11);
        drive(1'b1, 8'd80, 8'h22);
        drive(1'b0, 8'd80, 8'h00);
        rsp("rd80", 1'b0, 8'h22);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("mid_busy", busy, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_rsp_valid", rsp_valid, 1'b0);
        chk("abort_rsp_err", rsp_err, 1'b0);
        chk("abort_rsp_rdata", rsp_rdata, 8'h00);
        chk("abort_err_count", err_count, 8'h00);
        chk("abort_busy", busy, 1'b1);
        cyc(); cyc();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            cyc();
            cnt++;
            if (!busy) break;
        end
        chk("restart_clear_len", cnt, 64);
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 8'(64 + i), 8'h00);
            chk($sformatf("word%0d_rdata", i), rsp_rdata, 8'h00);
            chk($sformatf("word%0d_err", i), rsp_err, 1'b0);
        end
        chk("final_err_count", err_count, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
